varint_decoder: RTL
===================

// Module: varint_decoder
// PURPOSE
//  Upstream stage of the varint output FIFO. Consumes the protobuf wire byte stream one byte per cycle
//  and assembles base-128 varints (LSB group first, bit7 = continuation). Pushes each completed value into
//  the varint out FIFO, whose pop side is drained by the varint handshake FSM.
// PARAMETERS
//  DATA_W     64  width of assembled varint value
//  MAX_BYTES  10  max encoded length accepted (ceil(DATA_W/7))
//  LEN_W      4   width of byte-count output, must hold MAX_BYTES
// PORTS
//  clk                    in   1       single clock, all logic rising-edge
//  reset                  in   1       asynchronous, active-low reset
//  byte_in_valid          in   1       byte_in holds a valid stream byte
//  byte_in                in   8       stream byte
//  byte_in_ready          out  1       decoder accepts byte this cycle
//  varint_out_fifo_full   in   1       output FIFO cannot take a push
//  varint_out_push        out  1       push strobe into output FIFO
//  varint_out_data        out  DATA_W  decoded value
//  varint_out_len         out  LEN_W   encoded byte count of the value
//  varint_err_overlong    out  1       1-cycle pulse: overlong varint dropped
// BEHAVIOUR
//  - Reset (reset=0, async): state=ACCUM, acc=0, idx=0, varint_out_data=0, varint_out_len=0.
//    Outputs at reset: byte_in_ready=1, varint_out_push=0, varint_err_overlong=0. Mid-varint reset discards the partial value.
//  - Handshake: byte transfers on rising edge with byte_in_valid & byte_in_ready.
//    byte_in_ready = (state==ACCUM), combinational from state only.
//  - ACCUM: on accept, acc |= byte_in[6:0] << (7*idx), bits beyond DATA_W truncated; idx++ (saturate at MAX_BYTES).
//    If byte_in[7]==0: latch varint_out_data=merged acc, varint_out_len=idx+1, go EMIT.
//  - EMIT: varint_out_push = (state==EMIT) & ~varint_out_fifo_full (combinational).
//    When push=1: clear acc/idx, go ACCUM next cycle. While full=1: hold EMIT, data/len stable, ready=0.
//  - Latency: terminating byte accepted at edge N -> push during cycle N+1 if FIFO not full.
//    Throughput: one n-byte varint per n+1 cycles.
//  - Byte 10 at DATA_W=64: only bit0 contributes; higher payload bits silently dropped.
//  - No input between bytes of one varint (byte_in_valid=0): state/acc held indefinitely.
// CONFIGURATION
//  VARINT_OVERLONG_CHK_EN defined:
//   - Accepting a byte with bit7=1 when idx==MAX_BYTES-1 enters state DRAIN.
//   - DRAIN: byte_in_ready=1; bytes discarded until a byte with bit7=0 is accepted.
//   - On that byte: varint_err_overlong=1 for one cycle, no push, acc/idx cleared, go ACCUM.
//  VARINT_OVERLONG_CHK_EN undefined:
//   - No DRAIN state; varint_err_overlong tied 0.
//   - Bytes past MAX_BYTES are accepted with payload ignored; value emitted normally, len=MAX_BYTES.
// STRUCTURE
//  - Shared package/include varint_defs: state encoding (ACCUM, EMIT, DRAIN), VARINT_MAX_BYTES,
//    VARINT_DATA_W defaults, and the continuation-bit index constant (7).
//  - One sub-module: varint_group_merge (comb): acc, idx, 7-bit payload -> merged acc with DATA_W truncation.
//    FSM, counters and output registers stay in varint_decoder.
// TESTING
//  1 Single byte 0x05, fifo not full -> push 1 cycle after accept, data=0x5, len=1; ready low that cycle.
//  2 Bytes 0xAC,0x02 back-to-back -> data=300 (0x12C), len=2, push on cycle after 0x02 accepted.
//  3 0xFF x9 then 0x01 -> data=0xFFFF_FFFF_FFFF_FFFF, len=10, err_overlong=0.
//  4 Backpressure: 0x7F with fifo_full=1 for 3 cycles -> push=0, ready=0, data=0x7F stable;
//    single push when full drops, then ACCUM.
//  5 Overlong: 0x80 x11 then 0x00 -> with _EN: no push, err_overlong pulse on 0x00 accept;
//    without _EN: push data=0, len=10.
//  6 Reset mid-varint after 0x81 -> then 0x03 -> data=0x3, len=1, no residue from 0x81.

Source files
------------

// File: rtl/varint_defs_pkg.sv
// Shared definitions for the varint decoder: state encoding, default sizes
// and the continuation-bit position of a wire byte.
package varint_defs;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int VARINT_DATA_W    = 64;
  localparam int VARINT_MAX_BYTES = 10;
  localparam int VARINT_LEN_W     = 4;
  localparam int CONT_BIT         = 7;

endpackage

// File: rtl/varint_group_merge.sv
// Combinational merge of one 7-bit payload group into the partial varint.
// Groups at or past MAX_BYTES contribute nothing; bits past DATA_W are cut.
module varint_group_merge
  import varint_defs::*;
#(
  parameter int DATA_W    = VARINT_DATA_W,
  parameter int MAX_BYTES = VARINT_MAX_BYTES,
  parameter int LEN_W     = VARINT_LEN_W
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [LEN_W-1:0]  idx,
  input  logic [6:0]        payload,
  output logic [DATA_W-1:0] merged
);

  logic [DATA_W+6:0] wide;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    wide    = '0;
    shifted = '0;
    for (int g = 0; g < MAX_BYTES; g++) begin
      if (idx == LEN_W'(g)) begin
        wide    = (DATA_W+7)'(payload) << (7 * g);
        shifted = wide[DATA_W-1:0];
      end
    end
    merged = acc | shifted;
  end

endmodule

// File: rtl/varint_decoder.sv
// Base-128 varint decoder feeding the varint output FIFO, one byte per cycle.
// Optional overlong detection/drain is enabled with VARINT_OVERLONG_CHK_EN.
module varint_decoder
  import varint_defs::*;
#(
  parameter int DATA_W    = VARINT_DATA_W,
  parameter int MAX_BYTES = VARINT_MAX_BYTES,
  parameter int LEN_W     = VARINT_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_in_valid,
  input  logic [7:0]        byte_in,
  output logic              byte_in_ready,
  input  logic              varint_out_fifo_full,
  output logic              varint_out_push,
  output logic [DATA_W-1:0] varint_out_data,
  output logic [LEN_W-1:0]  varint_out_len,
  output logic              varint_err_overlong,
  output logic [1:0]        fsm_state
);

  // Handshake: a byte moves on a rising edge where byte_in_valid & byte_in_ready;
  // a value moves into the FIFO on a rising edge where varint_out_push is high.

  state_t            state, next_state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] merged;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_inc;
  logic              accept;
  logic              last_byte;

  assign accept    = byte_in_valid & byte_in_ready;
  assign last_byte = ~byte_in[CONT_BIT];
  assign idx_inc   = (idx == LEN_W'(MAX_BYTES)) ? idx : idx + LEN_W'(1);
  assign fsm_state = state;

  varint_group_merge #(
    .DATA_W    (DATA_W),
    .MAX_BYTES (MAX_BYTES),
    .LEN_W     (LEN_W)
  ) u_merge (
    .acc     (acc),
    .idx     (idx),
    .payload (byte_in[6:0]),
    .merged  (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_ACCUM;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_ACCUM: begin
        if (accept && last_byte) next_state = ST_EMIT;
`ifdef VARINT_OVERLONG_CHK_EN
        else if (accept && idx == LEN_W'(MAX_BYTES - 1)) next_state = ST_DRAIN;
`endif
      end
      ST_EMIT: begin
        if (!varint_out_fifo_full) next_state = ST_ACCUM;
      end
`ifdef VARINT_OVERLONG_CHK_EN
      ST_DRAIN: begin
        if (accept && last_byte) next_state = ST_ACCUM;
      end
`endif
      default: next_state = ST_ACCUM;
    endcase
  end

  always_comb begin
    byte_in_ready   = (state == ST_ACCUM);
`ifdef VARINT_OVERLONG_CHK_EN
    if (state == ST_DRAIN) byte_in_ready = 1'b1;
`endif
    varint_out_push = (state == ST_EMIT) && !varint_out_fifo_full;
  end

`ifdef VARINT_OVERLONG_CHK_EN
  logic err_q;
  assign varint_err_overlong = err_q;
`else
  assign varint_err_overlong = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc             <= '0;
      idx             <= '0;
      varint_out_data <= '0;
      varint_out_len  <= '0;
`ifdef VARINT_OVERLONG_CHK_EN
      err_q           <= 1'b0;
`endif
    end else begin
`ifdef VARINT_OVERLONG_CHK_EN
      err_q <= 1'b0;
`endif
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            acc <= merged;
            idx <= idx_inc;
            if (last_byte) begin
              varint_out_data <= merged;
              varint_out_len  <= idx_inc;
            end
          end
        end
        ST_EMIT: begin
          if (varint_out_push) begin
            acc <= '0;
            idx <= '0;
          end
        end
`ifdef VARINT_OVERLONG_CHK_EN
        // Discarded tail of an overlong varint; only its end is reported.
        ST_DRAIN: begin
          if (accept && last_byte) begin
            err_q <= 1'b1;
            acc   <= '0;
            idx   <= '0;
          end
        end
`endif
        default: begin
          acc <= '0;
          idx <= '0;
        end
      endcase
    end
  end

endmodule
